x_uart_tx_fifo: RTL and testbench

//  - Buffered UART transmitter: accepts bytes on a valid/ready interface into a small FIFO and

---
 rtl/x_uart_tx_fifo.sv | 112 +++++++++++
 tb/tb_x_uart_tx_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/x_uart_tx_fifo.sv
// x_uart_tx_fifo: FIFO-buffered 8N1/8N2 UART transmitter.
// Optional even parity bit after the data bits when X_UART_TX_PARITY_EN is defined.
module x_uart_tx_fifo #(
  parameter int p_clk_hz    = 10000000,
  parameter int p_baud      = 115200,
  parameter int p_depth     = 4,
  parameter int p_stop_bits = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [7:0]                i_data,
  output logic                      o_ready,
  output logic [$clog2(p_depth):0]  o_level,
  output logic                      o_busy,
  output logic                      o_tx
);
  localparam int TOP = p_clk_hz / p_baud;
  localparam int TW  = $clog2(TOP);
  localparam int AW  = $clog2(p_depth);
  localparam int LW  = AW + 1;
`ifdef X_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t          state;
  logic [7:0]      mem [p_depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      shift;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic            tick, last_stop, push, pop;
  always_comb begin
    tick      = timer == TW'(TOP - 1);
    last_stop = bit_cnt == 3'(p_stop_bits - 1);
    o_ready   = o_level != LW'(p_depth);
    o_busy    = state != IDLE;
    push      = i_valid && o_ready;
    // a new frame starts from IDLE or straight off the end of the last stop bit
    pop       = (o_level != '0) && (state == IDLE || (state == STOP && tick && last_stop));
  end
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_level <= (push && !pop) ? o_level + 1'b1 : (pop && !push) ? o_level - 1'b1 : o_level;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      timer   <= '0;
      bit_cnt <= '0;
      o_tx    <= 1'b1;
`ifdef X_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      timer <= (state == IDLE || tick) ? '0 : timer + 1'b1;
      if (pop) begin
        state   <= START;
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
        o_tx    <= 1'b0;
`ifdef X_UART_TX_PARITY_EN
        par     <= ^mem[rd_ptr];
`endif
      end else if (tick) begin
        case (state)
          START: begin
            state <= DATA;
            o_tx  <= shift[0];
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef X_UART_TX_PARITY_EN
              state   <= PARITY;
              o_tx    <= par;
`else
              state   <= STOP;
              o_tx    <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              o_tx    <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef X_UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            o_tx  <= 1'b1;
          end
`endif
          STOP: begin
            bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
            if (last_stop) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_x_uart_tx_fifo.sv
// tb_x_uart_tx_fifo: scoreboard bench; a line monitor decodes o_tx cycle by cycle.
// Honours X_UART_TX_PARITY_EN to expect the even parity bit.
module tb_x_uart_tx_fifo;
  localparam int TOP = 86;
`ifdef X_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int EXPF = 15;
`else
  localparam int NB = 10;
  localparam int EXPF = 13;
`endif
  localparam int FRAME = NB * TOP;
  logic       i_clk = 1'b0, i_rst_n, i_valid, o_ready, o_busy, o_tx;
  logic [7:0] i_data;
  logic [2:0] o_level;
  int pass_n = 0, total_n = 0, cyc = 0, m_frames = 0, p, n, guard;
  logic [7:0] q[$];
  int start_q[$];
  logic mon_busy = 1'b0, m_ab, m_ok, acc;
  logic [7:0] m_b;
  logic [NB-1:0] m_bits;

  x_uart_tx_fifo #(.p_clk_hz(10000000), .p_baud(115200), .p_depth(4), .p_stop_bits(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_level(o_level), .o_busy(o_busy), .o_tx(o_tx));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    logic a;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = b;
    a = o_ready;
    @(posedge i_clk);
    if (a) q.push_back(b);
    @(negedge i_clk);
    i_valid = 1'b0;
    p = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (3) @(negedge i_clk);
    while ((o_busy || mon_busy || q.size() != 0) && k < 10000) begin
      @(negedge i_clk);
      k++;
    end
    repeat (2) @(negedge i_clk);
    chk("idle_timeout", k < 10000, 1);
  endtask

  // line monitor: every bit of each frame must hold its expected value for exactly TOP cycles
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && o_tx === 1'b0) begin
      mon_busy = 1'b1;
      start_q.push_back(cyc);
      if (q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        m_b = 8'h00;
      end else m_b = q.pop_front();
`ifdef X_UART_TX_PARITY_EN
      m_bits = {1'b1, ^m_b, m_b, 1'b0};
`else
      m_bits = {1'b1, m_b, 1'b0};
`endif
      m_ab = 1'b0;
      for (int k = 0; k < NB && !m_ab; k++) begin
        m_ok = 1'b1;
        for (int c = 0; c < TOP && !m_ab; c++) begin
          if (k != 0 || c != 0) @(negedge i_clk);
          if (!i_rst_n) m_ab = 1'b1;
          else if (o_tx !== m_bits[k]) m_ok = 1'b0;
        end
        if (!m_ab) chk($sformatf("byte%02h_bit%0d", m_b, k), m_ok, 1);
      end
      if (!m_ab) m_frames++;
      mon_busy = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_level", o_level, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    // single byte: latency, frame length
    start_q.delete();
    push(8'h55);
    while (cyc < p + FRAME) @(negedge i_clk);
    chk("busy_last_cycle", o_busy, 1);
    @(negedge i_clk);
    chk("busy_after_frame", o_busy, 0);
    chk("latency", start_q.size() > 0 ? start_q[0] : -1, p + 1);
    wait_idle();
    // back-to-back frames with no idle gap
    start_q.delete();
    push(8'hA5);
    n = p;
    push(8'h3C);
    wait_idle();
    chk("b2b_count", start_q.size(), 2);
    chk("b2b_first", start_q.size() > 1 ? start_q[0] : -1, n + 1);
    chk("b2b_gap", start_q.size() > 1 ? start_q[1] - start_q[0] : -1, FRAME);
    // hold valid: one pops immediately, four fill the FIFO, then full
    n = 0;
    guard = 0;
    i_valid = 1'b1;
    while (n < 5 && guard < 100) begin
      i_data = 8'h10 + 8'(n);
      acc = o_ready;
      @(posedge i_clk);
      if (acc) begin
        q.push_back(i_data);
        n++;
      end
      @(negedge i_clk);
      guard++;
    end
    chk("fill_level", o_level, 4);
    chk("fill_ready", o_ready, 0);
    i_data = 8'h15;
    repeat (5) @(negedge i_clk);
    chk("full_level_held", o_level, 4);
    chk("full_ready_held", o_ready, 0);
    i_valid = 1'b0;
    wait_idle();
    // push and pop on the same edge at level 2
    push(8'h00);
    n = p;
    push(8'hFF);
    push(8'h33);
    chk("level_two", o_level, 2);
    while (cyc < n + FRAME - 1) @(negedge i_clk);
    chk("level_before_pp", o_level, 2);
    push(8'h44);
    chk("level_after_pp", o_level, 2);
    chk("busy_after_pp", o_busy, 1);
    wait_idle();
    // asynchronous reset mid-frame
    push(8'h99);
    push(8'h12);
    repeat (300) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_tx", o_tx, 1);
    chk("arst_level", o_level, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_ready", o_ready, 1);
    q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("post_rst_busy", o_busy, 0);
    push(8'h81);
    wait_idle();
`ifdef X_UART_TX_PARITY_EN
    start_q.delete();
    push(8'h07);
    push(8'h03);
    wait_idle();
    chk("par_gap", start_q.size() > 1 ? start_q[1] - start_q[0] : -1, 946);
`endif
    chk("scoreboard_empty", q.size(), 0);
    chk("frames", m_frames, EXPF);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
